bus_slave_port: RTL and testbench

Bit-serial slave-side endpoint for the system bus: the responder that the master port's serial initiator talks to. It deserialises address and write data from the master, performs the access on a local memory through a simple synchronous memory port, and serialises read data back to the master. It supports single and incrementing-burst transfers and sits between the bus interconnect and each slave's memory block.

---
 rtl/bus_slave_port.sv | 212 +++++++++++++++++++++
 tb/tb_bus_slave_port.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_port.sv
// bus_slave_port: bit-serial slave endpoint of the system bus.
// Deserialises an LSB-first address (and write data) from the master, performs
// single or incrementing-burst accesses on a synchronous local memory port, and
// serialises read data back to the master LSB first.
//
// Ports:
//   clock, rst            clock (rising edge) and asynchronous active-low reset
//   slave_valid/slave_rx  request bit strobe and serial request line
//   slave_mode            1 = write, 0 = read (taken with address bit 0)
//   slave_burst           burst length minus 1 (taken with address bit 0)
//   slave_ready           slave accepts request bits this cycle
//   slave_tx/_valid       serial read data and its strobe
//   mem_addr/mem_wdata    memory address and write data
//   mem_we/mem_re         one-cycle write / read strobes
//   mem_rdata             read data, valid one cycle after mem_re
module bus_slave_port #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  slave_valid,
    input  logic                  slave_rx,
    input  logic                  slave_mode,
    input  logic [3:0]            slave_burst,
    output logic                  slave_ready,
    output logic                  slave_tx,
    output logic                  slave_tx_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WRITE,
        ST_RREQ,
        ST_RLOAD,
        ST_RDATA
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            words_q, words_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wsr_q, wsr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;

    logic                  ready_q, ready_d;
    logic                  tx_q, tx_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;

    // LSB-first shift-in: new bit enters at the MSB, so after a full word
    // the first received bit sits at bit 0.
    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [DATA_WIDTH-1:0] wsr_shift;
    assign addr_shift = (addr_q >> 1) | (ADDR_WIDTH'(slave_rx) << (ADDR_WIDTH - 1));
    assign wsr_shift  = (wsr_q  >> 1) | (DATA_WIDTH'(slave_rx) << (DATA_WIDTH - 1));

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        words_d  = words_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        wsr_d    = wsr_q;
        tx_sr_d  = tx_sr_q;

        case (state_q)
            ST_IDLE: begin
                if (slave_valid) begin
                    mode_d  = slave_mode;
                    words_d = slave_burst;
                    addr_d  = addr_shift;
                    if (ADDR_WIDTH == 1) begin
                        cnt_d   = '0;
                        state_d = slave_mode ? ST_WDATA : ST_RREQ;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (slave_valid) begin
                    addr_d = addr_shift;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = mode_q ? ST_WDATA : ST_RREQ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WDATA: begin
                if (slave_valid) begin
                    wsr_d = wsr_shift;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (words_q != 4'd0) begin
                    words_d = words_q - 4'd1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RREQ: begin
                state_d = ST_RLOAD;
            end
            ST_RLOAD: begin
                tx_sr_d = mem_rdata;
                cnt_d   = '0;
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                tx_sr_d = tx_sr_q >> 1;
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (words_q != 4'd0) begin
                        words_d = words_q - 4'd1;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_RREQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state will present,
        // so they line up with state_q exactly.
        ready_d     = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
        mem_we_d    = (state_d == ST_WRITE);
        mem_re_d    = (state_d == ST_RREQ);
        tx_valid_d  = (state_d == ST_RDATA);
        tx_d        = tx_valid_d ? tx_sr_d[0] : 1'b0;
        mem_addr_d  = (mem_we_d || mem_re_d) ? addr_d : mem_addr_q;
        mem_wdata_d = mem_we_d ? wsr_d : mem_wdata_q;
    end

    // State and output registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            words_q     <= '0;
            mode_q      <= 1'b0;
            addr_q      <= '0;
            wsr_q       <= '0;
            tx_sr_q     <= '0;
            ready_q     <= 1'b1;
            tx_q        <= 1'b0;
            tx_valid_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            wsr_q       <= wsr_d;
            tx_sr_q     <= tx_sr_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            tx_valid_q  <= tx_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign slave_ready    = ready_q;
    assign slave_tx       = tx_q;
    assign slave_tx_valid = tx_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_we         = mem_we_q;
    assign mem_re         = mem_re_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Scoreboard bench for bus_slave_port: the driver pushes expected memory strobes
// and serial read bits (with their expected cycles) as frames are issued; a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_bus_slave_port;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic          clock = 1'b0;
    logic          rst   = 1'b0;
    logic          slave_valid = 1'b0;
    logic          slave_rx    = 1'b0;
    logic          slave_mode  = 1'b0;
    logic [3:0]    slave_burst = 4'd0;
    logic          slave_ready;
    logic          slave_tx;
    logic          slave_tx_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = '0;

    bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock          (clock),
        .rst            (rst),
        .slave_valid    (slave_valid),
        .slave_rx       (slave_rx),
        .slave_mode     (slave_mode),
        .slave_burst    (slave_burst),
        .slave_ready    (slave_ready),
        .slave_tx       (slave_tx),
        .slave_tx_valid (slave_tx_valid),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_rdata      (mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s (t=%0t cyc=%0d)", name, detail, $time, cyc);
    endtask

    // Default memory content, shared by the DUT-side memory and the model.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'(a * 13) ^ DW'(a >> 4);
    endfunction

    // Memory attached to the DUT port: rdata valid one cycle after mem_re.
    logic [DW-1:0] dut_mem [int];
    always @(posedge clock) begin
        if (mem_we) dut_mem[int'(mem_addr)] = mem_wdata;
        if (mem_re) mem_rdata <= dut_mem.exists(int'(mem_addr)) ? dut_mem[int'(mem_addr)]
                                                                : init_val(mem_addr);
    end

    // Reference model memory
    logic [DW-1:0] ref_mem [int];
    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    typedef enum int {EV_WE, EV_RE, EV_TX} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;
    ev_t exp_q[$];

    // Monitor: every presented output event is popped and compared.
    ev_t      mon_e;
    ev_kind_t mon_k;
    always @(negedge clock) begin
        if (rst) begin
            if (!slave_tx_valid)
                chk(slave_tx == 1'b0, "tx_idle_zero", $sformatf("slave_tx=%0b expected 0", slave_tx));
            if (mem_we || mem_re || slave_tx_valid) begin
                mon_k = mem_we ? EV_WE : (mem_re ? EV_RE : EV_TX);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_event",
                        $sformatf("kind=%s addr=%03h wdata=%02h tx=%0b, none expected",
                                  mon_k.name(), mem_addr, mem_wdata, slave_tx));
                end else begin
                    mon_e = exp_q.pop_front();
                    case (mon_e.kind)
                        EV_WE: chk(mon_k == EV_WE && cyc == mon_e.cyc && mem_addr == mon_e.addr
                                   && mem_wdata == mon_e.data, "mem_write",
                                   $sformatf("got %s cyc=%0d addr=%03h data=%02h, expected WE cyc=%0d addr=%03h data=%02h",
                                             mon_k.name(), cyc, mem_addr, mem_wdata, mon_e.cyc, mon_e.addr, mon_e.data));
                        EV_RE: chk(mon_k == EV_RE && cyc == mon_e.cyc && mem_addr == mon_e.addr, "mem_read",
                                   $sformatf("got %s cyc=%0d addr=%03h, expected RE cyc=%0d addr=%03h",
                                             mon_k.name(), cyc, mem_addr, mon_e.cyc, mon_e.addr));
                        default: chk(mon_k == EV_TX && cyc == mon_e.cyc && slave_tx == mon_e.data[0], "tx_bit",
                                   $sformatf("got %s cyc=%0d tx=%0b, expected TX cyc=%0d tx=%0b (addr %03h)",
                                             mon_k.name(), cyc, slave_tx, mon_e.cyc, mon_e.data[0], mon_e.addr));
                    endcase
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk(slave_ready == 1'b1,    {tag, "_ready"},    $sformatf("got %0b expected 1", slave_ready));
        chk(slave_tx == 1'b0,       {tag, "_tx"},       $sformatf("got %0b expected 0", slave_tx));
        chk(slave_tx_valid == 1'b0, {tag, "_tx_valid"}, $sformatf("got %0b expected 0", slave_tx_valid));
        chk(mem_addr == '0,         {tag, "_mem_addr"}, $sformatf("got %03h expected 000", mem_addr));
        chk(mem_wdata == '0,        {tag, "_mem_wdata"},$sformatf("got %02h expected 00", mem_wdata));
        chk(mem_we == 1'b0,         {tag, "_mem_we"},   $sformatf("got %0b expected 0", mem_we));
        chk(mem_re == 1'b0,         {tag, "_mem_re"},   $sformatf("got %0b expected 0", mem_re));
    endtask

    // Present one bit until a ready cycle takes it; returns the accept cycle.
    // Called and returns at posedge+1.
    task automatic send_bit(input logic b, input int gap, output int acc);
        logic r;
        int   c;
        repeat (gap) begin
            slave_valid = 1'b0;
            slave_rx    = 1'($urandom);
            @(posedge clock); #1;
        end
        acc = -1;
        for (int k = 0; k < 200; k++) begin
            slave_valid = 1'b1;
            slave_rx    = b;
            @(negedge clock);
            r = slave_ready;
            c = cyc;
            @(posedge clock); #1;
            if (r) begin
                acc = c;
                break;
            end
        end
        if (acc < 0) chk(1'b0, "bit_accept_timeout", "slave_ready stayed 0 for 200 cycles, expected 1");
    endtask

    // Wait for slave_ready with junk on the request lines; compare return cycle.
    task automatic wait_ready(input int exp_cyc);
        int got = -1;
        for (int k = 0; k < 400; k++) begin
            slave_valid = 1'b1;
            slave_rx    = 1'($urandom);
            slave_mode  = 1'($urandom);
            slave_burst = 4'($urandom);
            @(negedge clock);
            if (slave_ready) begin
                slave_valid = 1'b0;
                got = cyc;
                break;
            end
            @(posedge clock); #1;
        end
        chk(got == exp_cyc, "ready_return", $sformatf("ready at cyc %0d expected %0d", got, exp_cyc));
        @(posedge clock); #1;
    endtask

    function automatic int pick_gap(input int gap_mode, input bool_first);
        if (gap_mode == 1) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (gap_mode == 2 && !bool_first) return 3;
        return 0;
    endfunction

    logic [DW-1:0] wdat [16];

    // Issue one frame. gap_mode 0: continuous; 1: random gaps; 2: 3-cycle gaps
    // inside the address. abort_bit >= 0 asserts reset after that many data bits.
    task automatic do_frame(input bit wr, input logic [3:0] burst, input logic [AW-1:0] addr,
                            input int gap_mode, input int abort_bit);
        int            acc;
        int            last;
        int            nbits;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        ev_t           e;
        slave_mode  = wr;
        slave_burst = burst;
        acc = 0;
        for (int i = 0; i < int'(AW); i++) begin
            send_bit(addr[i], pick_gap(gap_mode, i == 0), acc);
            if (i == 0) begin
                slave_mode  = 1'($urandom);
                slave_burst = 4'($urandom);
            end
        end
        last = acc;
        a = addr;
        if (wr) begin
            nbits = 0;
            for (int w = 0; w <= int'(burst); w++) begin
                v = wdat[w];
                for (int i = 0; i < int'(DW); i++) begin
                    send_bit(v[i], (gap_mode == 1) ? pick_gap(1, 1'b0) : 0, acc);
                    nbits++;
                    if (abort_bit >= 0 && nbits == abort_bit) begin
                        #2 rst = 1'b0;
                        #1 check_reset_vals("midreset");
                        slave_valid = 1'b0;
                        repeat (3) @(posedge clock);
                        @(negedge clock); #2 rst = 1'b1;
                        @(posedge clock); #1;
                        return;
                    end
                end
                e.kind = EV_WE; e.addr = a; e.data = v; e.cyc = acc + 1;
                exp_q.push_back(e);
                ref_mem[int'(a)] = v;
                a = a + AW'(1);
            end
            wait_ready(acc + 2);
        end else begin
            for (int w = 0; w <= int'(burst); w++) begin
                e.kind = EV_RE; e.addr = a; e.data = '0; e.cyc = last + 1 + w * int'(DW + 2);
                exp_q.push_back(e);
                v = ref_rd(a);
                for (int i = 0; i < int'(DW); i++) begin
                    e.kind = EV_TX; e.data = DW'(v[i]); e.cyc = last + 3 + w * int'(DW + 2) + i;
                    exp_q.push_back(e);
                end
                a = a + AW'(1);
            end
            wait_ready(last + 3 + int'(DW) + int'(burst) * int'(DW + 2));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 check_reset_vals("reset");
        @(negedge clock); #2 rst = 1'b1;
        @(posedge clock); #1;

        // Single write 0x012 <- 0xA5, then read it back
        wdat[0] = 8'hA5;
        do_frame(1'b1, 4'd0, 12'h012, 0, -1);
        do_frame(1'b0, 4'd0, 12'h012, 0, -1);

        // Burst write with address wrap, then read the four words back
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
        do_frame(1'b1, 4'd3, 12'hFFE, 0, -1);
        do_frame(1'b0, 4'd3, 12'hFFE, 1, -1);

        // Two-word read with 3-cycle gaps inside the address
        do_frame(1'b0, 4'd1, 12'h100, 2, -1);

        // Reset during the second word of a 4-word write burst
        for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
        do_frame(1'b1, 4'd3, 12'h200, 0, int'(DW) + 3);
        do_frame(1'b0, 4'd3, 12'h200, 0, -1);

        // Fresh single write after reset release, read back
        wdat[0] = 8'h5C;
        do_frame(1'b1, 4'd0, 12'h345, 0, -1);
        do_frame(1'b0, 4'd0, 12'h345, 1, -1);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom);
            do_frame(1'($urandom), 4'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) == 0) ? AW'($urandom_range(4092, 4095)) : AW'($urandom),
                     int'($urandom_range(0, 1)), -1);
        end

        slave_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1 chk(exp_q.size() == 0, "scoreboard_drain",
               $sformatf("%0d expected events never seen, expected 0", exp_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
